// File: rtl/fsm_fpu.sv
// Multi-cycle control FSM for the single-precision FP path: decode, operand load, unit handshake, FLW/FSW, writeback.
// Optional WAIT watchdog is compiled in with FSM_FPU_WATCHDOG_EN.
module fsm_fpu #(
    parameter int WATCHDOG_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] ins,
    input  logic [2:0]  frm,
    input  logic        unit_done,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        timeout,
    output logic [2:0]  func3,
    output logic [2:0]  rm,
    output logic [2:0]  sel_fu,
    output logic        fu_sub,
    output logic        fu_start,
    output logic        load_rs1,
    output logic        load_rs2,
    output logic        sel_rs1_int,
    output logic        load_alu,
    output logic        sel_alu_b,
    output logic        load_data_memory,
    output logic        write_mem,
    output logic        load_fregfile,
    output logic        load_regfile
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_ADDR, S_MEM, S_EXEC, S_WAIT, S_WB, S_ABORT
    } state_t;

    localparam logic [6:0] OP_FP  = 7'b1010011;
    localparam logic [6:0] OP_FLW = 7'b0000111;
    localparam logic [6:0] OP_FSW = 7'b0100111;

    state_t      state_q;
    logic        busy_q, done_q, illegal_q, timeout_q, fu_sub_q, fu_start_q;
    logic [2:0]  func3_q, rm_q, sel_fu_q;
    logic        load_rs1_q, load_rs2_q, sel_rs1_int_q, load_alu_q, sel_alu_b_q;
    logic        load_data_memory_q, write_mem_q, load_fregfile_q, load_regfile_q;
    logic        bad_q, mem_q, store_q, multi_q, int_rd_q;

    // Decode of the word presented with start; the results are latched on acceptance.
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3_w, rm_w, sel_fu_w;
    logic        dec_illegal, dec_mem, dec_store, dec_multi, dec_int_rd;
    logic        dec_rs1_int, dec_sub, dec_rm_chk, dec_sqrt, f7_ok;

    always_comb begin
        opcode      = ins[6:0];
        funct7      = ins[31:25];
        funct3_w    = ins[14:12];
        rm_w        = (funct3_w == 3'b111) ? frm : funct3_w;
        sel_fu_w    = 3'd0;
        dec_illegal = 1'b0;
        dec_mem     = 1'b0;
        dec_store   = 1'b0;
        dec_multi   = 1'b0;
        dec_int_rd  = 1'b0;
        dec_rs1_int = 1'b0;
        dec_sub     = 1'b0;
        dec_rm_chk  = 1'b0;
        dec_sqrt    = 1'b0;
        f7_ok       = 1'b1;
        case (opcode)
            OP_FLW, OP_FSW: begin
                dec_mem     = 1'b1;
                dec_store   = (opcode == OP_FSW);
                dec_rs1_int = 1'b1;
                dec_illegal = (funct3_w != 3'b010);
            end
            OP_FP: begin
                case (funct7)
                    7'b0000000: begin sel_fu_w = 3'd0; dec_multi = 1'b1; dec_rm_chk = 1'b1; end
                    7'b0000100: begin sel_fu_w = 3'd0; dec_multi = 1'b1; dec_rm_chk = 1'b1; dec_sub = 1'b1; end
                    7'b0001000: begin sel_fu_w = 3'd1; dec_multi = 1'b1; dec_rm_chk = 1'b1; end
                    7'b0001100: begin sel_fu_w = 3'd2; dec_multi = 1'b1; dec_rm_chk = 1'b1; end
                    7'b0101100: begin sel_fu_w = 3'd3; dec_multi = 1'b1; dec_rm_chk = 1'b1; dec_sqrt = 1'b1; end
                    7'b0010000: sel_fu_w = 3'd4;
                    7'b0010100: sel_fu_w = 3'd5;
                    7'b1010000: begin sel_fu_w = 3'd6; dec_int_rd = 1'b1; end
                    7'b1100000: begin sel_fu_w = 3'd7; dec_multi = 1'b1; dec_rm_chk = 1'b1; dec_int_rd = 1'b1; end
                    7'b1101000: begin sel_fu_w = 3'd7; dec_multi = 1'b1; dec_rm_chk = 1'b1; dec_rs1_int = 1'b1; end
                    7'b1110000: begin sel_fu_w = 3'd7; dec_int_rd = 1'b1; end
                    7'b1111000: begin sel_fu_w = 3'd7; dec_rs1_int = 1'b1; end
                    default:    f7_ok = 1'b0;
                endcase
                // Resolved modes 101/110/111 are reserved for arithmetic that rounds.
                dec_illegal = !f7_ok
                            || (dec_sqrt && ins[24:20] != 5'd0)
                            || (dec_rm_chk && rm_w[2] && (rm_w[1] || rm_w[0]));
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    logic unused_ins_bits;
    assign unused_ins_bits = ^{ins[11:7], ins[19:15]};

    logic to_idle;
    assign to_idle = (state_q == S_DECODE && bad_q) || (state_q == S_MEM && store_q)
                   || (state_q == S_WB) || (state_q == S_ABORT);

`ifdef FSM_FPU_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_q;
`else
    logic unused_wd_limit;
    assign unused_wd_limit = (WATCHDOG_CYCLES != 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            {busy_q, done_q, illegal_q, timeout_q, fu_sub_q, fu_start_q} <= '0;
            {func3_q, rm_q, sel_fu_q} <= '0;
            {load_rs1_q, load_rs2_q, sel_rs1_int_q, load_alu_q, sel_alu_b_q} <= '0;
            {load_data_memory_q, write_mem_q, load_fregfile_q, load_regfile_q} <= '0;
            {bad_q, mem_q, store_q, multi_q, int_rd_q} <= '0;
`ifdef FSM_FPU_WATCHDOG_EN
            wd_cnt_q <= '0;
`endif
        end else begin
            {done_q, illegal_q, timeout_q, fu_start_q, load_rs1_q, load_rs2_q} <= '0;
            {load_alu_q, sel_alu_b_q, load_data_memory_q, write_mem_q} <= '0;
            {load_fregfile_q, load_regfile_q} <= '0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q       <= S_DECODE;
                    busy_q        <= 1'b1;
                    func3_q       <= funct3_w;
                    rm_q          <= rm_w;
                    sel_fu_q      <= sel_fu_w;
                    fu_sub_q      <= dec_sub;
                    sel_rs1_int_q <= dec_rs1_int;
                    bad_q         <= dec_illegal;
                    mem_q         <= dec_mem;
                    store_q       <= dec_store;
                    multi_q       <= dec_multi;
                    int_rd_q      <= dec_int_rd;
                    illegal_q     <= dec_illegal;
                    done_q        <= dec_illegal;
                    load_rs1_q    <= !dec_illegal;
                    load_rs2_q    <= !dec_illegal;
                end
                S_DECODE: if (!bad_q) begin
                    if (mem_q) begin
                        state_q     <= S_ADDR;
                        load_alu_q  <= 1'b1;
                        sel_alu_b_q <= 1'b1;
                    end else begin
                        state_q    <= S_EXEC;
                        fu_start_q <= 1'b1;
                    end
                end
                S_ADDR: begin
                    state_q            <= S_MEM;
                    write_mem_q        <= store_q;
                    done_q             <= store_q;
                    load_data_memory_q <= !store_q;
                end
                S_MEM: if (!store_q) begin
                    state_q         <= S_WB;
                    load_fregfile_q <= 1'b1;
                    done_q          <= 1'b1;
                end
                S_EXEC: if (multi_q) begin
                    state_q <= S_WAIT;
`ifdef FSM_FPU_WATCHDOG_EN
                    wd_cnt_q <= '0;
`endif
                end else begin
                    state_q         <= S_WB;
                    load_fregfile_q <= !int_rd_q;
                    load_regfile_q  <= int_rd_q;
                    done_q          <= 1'b1;
                end
                S_WAIT: if (unit_done) begin
                    state_q         <= S_WB;
                    load_fregfile_q <= !int_rd_q;
                    load_regfile_q  <= int_rd_q;
                    done_q          <= 1'b1;
                end
`ifdef FSM_FPU_WATCHDOG_EN
                else if (wd_cnt_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
                    state_q   <= S_ABORT;
                    timeout_q <= 1'b1;
                    done_q    <= 1'b1;
                end else begin
                    wd_cnt_q <= wd_cnt_q + 1'b1;
                end
`endif
                default: ;
            endcase
            if (to_idle) begin
                state_q <= S_IDLE;
                {busy_q, fu_sub_q, sel_rs1_int_q} <= '0;
                {func3_q, rm_q, sel_fu_q} <= '0;
                {bad_q, mem_q, store_q, multi_q, int_rd_q} <= '0;
            end
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign illegal          = illegal_q;
    assign timeout          = timeout_q;
    assign func3            = func3_q;
    assign rm               = rm_q;
    assign sel_fu           = sel_fu_q;
    assign fu_sub           = fu_sub_q;
    assign fu_start         = fu_start_q;
    assign load_rs1         = load_rs1_q;
    assign load_rs2         = load_rs2_q;
    assign sel_rs1_int      = sel_rs1_int_q;
    assign load_alu         = load_alu_q;
    assign sel_alu_b        = sel_alu_b_q;
    assign load_data_memory = load_data_memory_q;
    assign write_mem        = write_mem_q;
    assign load_fregfile    = load_fregfile_q;
    assign load_regfile     = load_regfile_q;
endmodule

// File: tb/tb_fsm_fpu.sv
// Directed bench for fsm_fpu: hand-decoded FP instructions with cycle-exact expected strobes.
module tb_fsm_fpu;
    logic        clk = 1'b0;
    logic        rst_n, start, unit_done;
    logic [31:0] ins;
    logic [2:0]  frm;
    logic        busy, done, illegal, timeout, fu_sub, fu_start, load_rs1, load_rs2, sel_rs1_int;
    logic        load_alu, sel_alu_b, load_data_memory, write_mem, load_fregfile, load_regfile;
    logic [2:0]  func3, rm, sel_fu;

    always #5 clk = ~clk;

    fsm_fpu #(.WATCHDOG_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ins(ins), .frm(frm), .unit_done(unit_done),
        .busy(busy), .done(done), .illegal(illegal), .timeout(timeout), .func3(func3), .rm(rm),
        .sel_fu(sel_fu), .fu_sub(fu_sub), .fu_start(fu_start), .load_rs1(load_rs1),
        .load_rs2(load_rs2), .sel_rs1_int(sel_rs1_int), .load_alu(load_alu), .sel_alu_b(sel_alu_b),
        .load_data_memory(load_data_memory), .write_mem(write_mem),
        .load_fregfile(load_fregfile), .load_regfile(load_regfile)
    );

    logic [23:0] all_outs;
    assign all_outs = {busy, done, illegal, timeout, func3, rm, sel_fu, fu_sub, fu_start, load_rs1,
                       load_rs2, sel_rs1_int, load_alu, sel_alu_b, load_data_memory, write_mem,
                       load_fregfile, load_regfile};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Per-transaction observations
    int   done_cyc, fu_cyc, fu_cnt, freg_cnt, reg_cnt, ill_cnt, to_cnt, addr_cyc, ldm_cyc;
    logic freg_at_done, reg_at_done, wm_at_done, ill_at_done, to_at_done, rs1int_at_addr;
    logic busy_last, busy_post;
    logic [2:0] sel_fu_c1, rm_c1, func3_c1, sel_fu_dn, func3_dn;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [31:0] word, input logic [2:0] frm_v,
                          input int delay, input logic [31:0] intrude, input int maxcyc);
        done_cyc = -1; fu_cyc = 0; fu_cnt = 0; freg_cnt = 0; reg_cnt = 0; ill_cnt = 0; to_cnt = 0;
        addr_cyc = 0; ldm_cyc = 0; rs1int_at_addr = 0; busy_post = 1'b1;
        {freg_at_done, reg_at_done, wm_at_done, ill_at_done, to_at_done} = '0;
        ins = word; frm = frm_v; start = 1'b1;
        tick();
        start = 1'b0; ins = 32'h0;
        for (int k = 1; k <= maxcyc; k++) begin
            if (k > 1) tick();
            unit_done = 1'b0; start = 1'b0;
            if (k == 1) begin sel_fu_c1 = sel_fu; rm_c1 = rm; func3_c1 = func3; end
            if (fu_start) begin fu_cnt++; fu_cyc = k; end
            if (load_fregfile) freg_cnt++;
            if (load_regfile) reg_cnt++;
            if (illegal) ill_cnt++;
            if (timeout) to_cnt++;
            if (load_alu && sel_alu_b) begin addr_cyc = k; rs1int_at_addr = sel_rs1_int; end
            if (load_data_memory) ldm_cyc = k;
            if (done) begin
                done_cyc = k; freg_at_done = load_fregfile; reg_at_done = load_regfile;
                wm_at_done = write_mem; ill_at_done = illegal; to_at_done = timeout;
                sel_fu_dn = sel_fu; func3_dn = func3;
                break;
            end
            if (fu_cyc > 0 && k == fu_cyc + delay) unit_done = 1'b1;
            if (intrude != 32'h0 && k == 3) begin start = 1'b1; ins = intrude; end
        end
        busy_last = busy;
        if (done_cyc > 0) begin
            tick();
            busy_post = busy;
        end
        $display("txn %s ins=%08h frm=%0d done_cyc=%0d fu=%0d freg=%0d reg=%0d ill=%0d to=%0d",
                 name, word, frm_v, done_cyc, fu_cnt, freg_cnt, reg_cnt, ill_cnt, to_cnt);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; ins = 32'h0; frm = 3'b000; unit_done = 1'b0;
        repeat (3) tick();
        check("reset_outs", {8'h0, all_outs}, 32'h0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", {31'h0, busy}, 32'h0);

        // fadd.s f3,f1,f2 with unit_done 5 cycles after fu_start
        run_op("fadd", 32'h002081D3, 3'b000, 5, 32'h0, 40);
        check("fadd_sel_fu", {29'h0, sel_fu_c1}, 32'd0);
        check("fadd_rm", {29'h0, rm_c1}, 32'd0);
        check("fadd_fu_cnt", fu_cnt, 1);
        check("fadd_done_cyc", done_cyc, 8);
        check("fadd_freg_at_done", {31'h0, freg_at_done}, 32'd1);
        check("fadd_reg_cnt", reg_cnt, 0);
        check("fadd_idle_after", {31'h0, busy_post}, 32'd0);

        // feq.s: unit_done in the EXEC cycle must be ignored
        run_op("feq", 32'hA020A2D3, 3'b000, 0, 32'h0, 40);
        check("feq_sel_fu", {29'h0, sel_fu_c1}, 32'd6);
        check("feq_func3", {29'h0, func3_c1}, 32'd2);
        check("feq_done_cyc", done_cyc, 3);
        check("feq_reg_at_done", {31'h0, reg_at_done}, 32'd1);
        check("feq_freg_cnt", freg_cnt, 0);

        run_op("flw", 32'h00812207, 3'b000, 0, 32'h0, 40);
        check("flw_addr_cyc", addr_cyc, 2);
        check("flw_rs1_int", {31'h0, rs1int_at_addr}, 32'd1);
        check("flw_ldm_cyc", ldm_cyc, 3);
        check("flw_done_cyc", done_cyc, 4);
        check("flw_freg_at_done", {31'h0, freg_at_done}, 32'd1);
        check("flw_fu_cnt", fu_cnt, 0);

        run_op("fsw", 32'h00412627, 3'b000, 0, 32'h0, 40);
        check("fsw_done_cyc", done_cyc, 3);
        check("fsw_wm_at_done", {31'h0, wm_at_done}, 32'd1);
        check("fsw_rf_strobes", freg_cnt + reg_cnt, 0);
        check("fsw_addr_cyc", addr_cyc, 2);

        run_op("fdiv_rm101", 32'h1820D1D3, 3'b000, 0, 32'h0, 40);
        check("fdiv101_done_cyc", done_cyc, 1);
        check("fdiv101_ill", {31'h0, ill_at_done}, 32'd1);
        check("fdiv101_fu_cnt", fu_cnt, 0);

        run_op("fdiv_dyn001", 32'h1820F1D3, 3'b001, 3, 32'h0, 40);
        check("fdivdyn_rm", {29'h0, rm_c1}, 32'd1);
        check("fdivdyn_sel_fu", {29'h0, sel_fu_c1}, 32'd2);
        check("fdivdyn_done_cyc", done_cyc, 6);
        check("fdivdyn_freg", {31'h0, freg_at_done}, 32'd1);
        check("fdivdyn_ill_cnt", ill_cnt, 0);

        run_op("fdiv_dyn110", 32'h1820F1D3, 3'b110, 3, 32'h0, 40);
        check("fdiv110_done_cyc", done_cyc, 1);
        check("fdiv110_ill", {31'h0, ill_at_done}, 32'd1);

        run_op("fsqrt_rs2", 32'h581081D3, 3'b000, 3, 32'h0, 40);
        check("fsqrt_rs2_ill", {31'h0, ill_at_done}, 32'd1);
        run_op("bad_opcode", 32'h00000013, 3'b000, 3, 32'h0, 40);
        check("bad_opcode_ill", {31'h0, ill_at_done}, 32'd1);

        // start with feq while fadd is busy: must not relatch
        run_op("fadd_intrude", 32'h002081D3, 3'b000, 5, 32'hA020A2D3, 40);
        check("intr_done_cyc", done_cyc, 8);
        check("intr_sel_fu", {29'h0, sel_fu_dn}, 32'd0);
        check("intr_func3", {29'h0, func3_dn}, 32'd0);
        check("intr_freg", {31'h0, freg_at_done}, 32'd1);
        check("intr_idle_after", {31'h0, busy_post}, 32'd0);

        // unit_done on the 8th WAIT cycle completes normally in either build
        run_op("fsqrt_late", 32'h580081D3, 3'b000, 8, 32'h0, 40);
        check("late_done_cyc", done_cyc, 11);
        check("late_freg", {31'h0, freg_at_done}, 32'd1);
        check("late_to_cnt", to_cnt, 0);

`ifdef FSM_FPU_WATCHDOG_EN
        run_op("fsqrt_wd", 32'h580081D3, 3'b000, 1000, 32'h0, 40);
        check("wd_done_cyc", done_cyc, 11);
        check("wd_timeout", {31'h0, to_at_done}, 32'd1);
        check("wd_no_wb", freg_cnt + reg_cnt, 0);
        check("wd_idle_after", {31'h0, busy_post}, 32'd0);
`else
        run_op("fsqrt_hang", 32'h580081D3, 3'b000, 1000, 32'h0, 40);
        check("nowd_no_done", done_cyc, -1);
        check("nowd_busy", {31'h0, busy_last}, 32'd1);
        check("nowd_to_cnt", to_cnt, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        // Asynchronous reset during fdiv WAIT
        ins = 32'h1820F1D3; frm = 3'b001; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("rst_busy_pre", {31'h0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outs", {8'h0, all_outs}, 32'h0);
        unit_done = 1'b1;
        tick();
        unit_done = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst_post_outs", {8'h0, all_outs}, 32'h0);
        $display("txn reset_mid_wait busy=%0b done=%0b", busy, done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
